// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection with branch decode, jumps, trap/eret,
// stall hold and misaligned-target rejection. Supplies fetch address and PC+4.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic [2:0]      br_type,
  input  logic            Zero,
  input  logic            Less,
  input  logic            LessU,
  input  logic [XLEN-1:0] Addr_result,
  input  logic            Jal,
  input  logic            Jr,
  input  logic [XLEN-1:0] rs_data,
  input  logic            trap,
  input  logic            eret,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus_4,
  output logic [XLEN-1:0] branch_base_addr,
  output logic [XLEN-1:0] epc,
  output logic            redirect,
  output logic            misaligned
);

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_misaligned;

  logic            w_taken;
  logic            w_has_target;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus_4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_epc_load;
  logic            w_reject;

  assign w_pc_plus_4 = r_pc + XLEN'(4);

  // Branch condition decode; reserved encoding behaves as no branch
  always_comb begin
    w_taken = 1'b0;
    case (br_type)
      BR_BEQ:  w_taken = Zero;
      BR_BNE:  w_taken = ~Zero;
      BR_BLT:  w_taken = Less;
      BR_BGE:  w_taken = ~Less;
      BR_BLTU: w_taken = LessU;
      BR_BGEU: w_taken = ~LessU;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-PC priority; only jump/branch targets are alignment-checked
  always_comb begin
    w_has_target = 1'b0;
    w_target     = w_pc_plus_4;
    w_next_pc    = w_pc_plus_4;
    w_epc_load   = 1'b0;
    w_reject     = 1'b0;
    if (trap) begin
      w_next_pc  = TRAP_VECTOR;
      w_epc_load = 1'b1;
    end else if (eret) begin
      w_next_pc = r_epc;
    end else begin
      if (Jr) begin
        w_has_target = 1'b1;
        w_target     = rs_data;
      end else if (Jal || w_taken) begin
        w_has_target = 1'b1;
        w_target     = Addr_result;
      end
      if (w_has_target && (w_target[1:0] != 2'b00)) begin
        w_next_pc  = TRAP_VECTOR;
        w_epc_load = 1'b1;
        w_reject   = 1'b1;
      end else begin
        w_next_pc = w_target;
      end
    end
  end

  // State update; reset beats stall, stall freezes everything else
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_misaligned <= 1'b0;
    end else if (!stall) begin
      r_pc         <= w_next_pc;
      r_misaligned <= w_reject;
      if (w_epc_load) begin
        r_epc <= r_pc;
      end
    end
  end

  assign PC               = r_pc;
  assign PC_plus_4        = w_pc_plus_4;
  assign branch_base_addr = r_pc;
  assign epc              = r_epc;
  assign misaligned       = r_misaligned;
  assign redirect         = ~stall && (w_next_pc != w_pc_plus_4);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed test-plan steps followed by random
// traffic, all checked against a next-PC reference model kept in the bench.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset, stall, Zero, Less, LessU, Jal, Jr, trap, eret;
  logic [2:0]  br_type;
  logic [31:0] Addr_result, rs_data;
  logic [31:0] PC, PC_plus_4, branch_base_addr, epc;
  logic        redirect, misaligned;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_mis;
  logic        m_valid = 1'b0;

  pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clock(clock), .reset(reset), .stall(stall), .br_type(br_type),
    .Zero(Zero), .Less(Less), .LessU(LessU), .Addr_result(Addr_result),
    .Jal(Jal), .Jr(Jr), .rs_data(rs_data), .trap(trap), .eret(eret),
    .PC(PC), .PC_plus_4(PC_plus_4), .branch_base_addr(branch_base_addr),
    .epc(epc), .redirect(redirect), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; br_type = 3'd0; Zero = 0; Less = 0; LessU = 0;
    Jal = 0; Jr = 0; trap = 0; eret = 0; Addr_result = '0; rs_data = '0;
  endtask

  // One clock: predict from the architectural rules, check combinational
  // outputs before the edge and registered outputs after it.
  task automatic cycle();
    logic [7:0]  cond;
    logic        has, bad, cap;
    logic [31:0] nxt, tgt;
    cond = {1'b0, !LessU, LessU, !Less, Less, !Zero, Zero, 1'b0};
    has = 1'b1; bad = 1'b0; cap = 1'b0; tgt = '0;
    if (trap) begin
      nxt = TV; cap = 1'b1;
    end else if (eret) begin
      nxt = m_epc;
    end else begin
      if (Jr)                 tgt = rs_data;
      else if (Jal)           tgt = Addr_result;
      else if (cond[br_type]) tgt = Addr_result;
      else                    has = 1'b0;
      if (!has)               nxt = m_pc + 32'd4;
      else if (tgt % 4 != 0) begin nxt = TV; cap = 1'b1; bad = 1'b1; end
      else                    nxt = tgt;
    end
    #1;
    if (m_valid) begin
      chk("pc_plus_4", PC_plus_4, m_pc + 32'd4);
      chk("branch_base", branch_base_addr, m_pc);
      chk("redirect", {31'b0, redirect}, {31'b0, (!stall && nxt != m_pc + 32'd4)});
    end
    @(posedge clock);
    if (reset) begin
      m_pc = RV; m_epc = '0; m_mis = 1'b0; m_valid = 1'b1;
    end else if (!stall) begin
      if (cap) m_epc = m_pc;
      m_pc  = nxt;
      m_mis = bad;
    end
    #1;
    if (m_valid) begin
      chk("pc", PC, m_pc);
      chk("epc", epc, m_epc);
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    end
  endtask

  task automatic jump(input logic [31:0] a);
    idle(); Jal = 1; Addr_result = a; cycle(); idle();
  endtask

  task automatic branch(input logic [2:0] bt, input logic z, input logic l, input logic lu);
    jump(32'h10);
    br_type = bt; Zero = z; Less = l; LessU = lu; Addr_result = 32'h40;
    cycle(); idle();
  endtask

  initial begin
    idle();
    reset = 1;
    cycle(); cycle();
    chk("tp_reset_pc", PC, 32'h0);
    chk("tp_reset_epc", epc, 32'h0);
    idle();
    cycle(); chk("tp_seq4", PC, 32'h4);
    cycle(); chk("tp_seq8", PC, 32'h8);
    cycle(); chk("tp_seq12", PC, 32'hC);

    branch(3'd1, 1, 0, 0); chk("tp_beq", PC, 32'h40);
    branch(3'd2, 1, 0, 0); chk("tp_bne", PC, 32'h14);
    branch(3'd3, 0, 1, 0); chk("tp_blt", PC, 32'h40);
    branch(3'd6, 0, 0, 1); chk("tp_bgeu", PC, 32'h14);
    branch(3'd7, 1, 1, 1); chk("tp_br7", PC, 32'h14);
    branch(3'd4, 0, 0, 0); chk("tp_bge", PC, 32'h40);
    branch(3'd5, 0, 0, 0); chk("tp_bltu_nt", PC, 32'h14);

    jump(32'h20);
    Jal = 1; Jr = 1; rs_data = 32'h80; Addr_result = 32'h60;
    cycle(); idle(); chk("tp_jr_over_jal", PC, 32'h80);
    jump(32'h24);
    trap = 1; eret = 1; cycle(); idle();
    chk("tp_trap_eret_pc", PC, 32'h100);
    chk("tp_trap_eret_epc", epc, 32'h24);

    jump(32'h30);
    trap = 1; cycle(); idle();
    chk("tp_trap_pc", PC, 32'h100); chk("tp_trap_epc", epc, 32'h30);
    eret = 1; cycle(); idle();
    chk("tp_eret_pc", PC, 32'h30); chk("tp_eret_epc", epc, 32'h30);

    jump(32'h50);
    Jr = 1; rs_data = 32'h42; cycle(); idle();
    chk("tp_mis_pc", PC, 32'h100); chk("tp_mis_epc", epc, 32'h50);
    chk("tp_mis_flag", {31'b0, misaligned}, 32'h1);
    cycle(); chk("tp_mis_clear", {31'b0, misaligned}, 32'h0);

    stall = 1; Jal = 1; Addr_result = 32'h200;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("tp_stall_pc", PC, 32'h104);
      chk("tp_stall_redirect", {31'b0, redirect}, 32'h0);
    end
    stall = 0; cycle(); idle(); chk("tp_stall_release", PC, 32'h200);

    Jal = 1; Addr_result = 32'h203; cycle(); idle();
    stall = 1; cycle(); cycle();
    chk("tp_mis_held", {31'b0, misaligned}, 32'h1);
    stall = 0; cycle(); chk("tp_mis_released", {31'b0, misaligned}, 32'h0);

    jump(32'hFFFF_FFFC);
    #1 chk("tp_wrap_p4", PC_plus_4, 32'h0);
    cycle(); chk("tp_wrap_pc", PC, 32'h0); chk("tp_wrap_p4b", PC_plus_4, 32'h4);
    reset = 1; stall = 1; trap = 1; cycle(); idle();
    chk("tp_rst_pc", PC, RV); chk("tp_rst_epc", epc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 49) == 0);
      stall   = ($urandom_range(0, 5) == 0);
      trap    = ($urandom_range(0, 11) == 0);
      eret    = ($urandom_range(0, 9) == 0);
      Jr      = ($urandom_range(0, 7) == 0);
      Jal     = ($urandom_range(0, 7) == 0);
      br_type = 3'($urandom_range(0, 7));
      Zero    = 1'($urandom); Less = 1'($urandom); LessU = 1'($urandom);
      Addr_result = {$urandom, 2'b00} | ($urandom_range(0, 5) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
      rs_data     = {$urandom, 2'b00} | ($urandom_range(0, 5) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
